im_loader: RTL

- Writer side of the instruction memory: receives a program as an 8-bit byte stream over a valid/ready handshake.
- Assembles every 3 bytes into one 24-bit instruction word and writes it into the instruction memory write port.
- Holds the CPU in reset (CpuHold) while loading, so instruction fetch via PC never sees a partial program.
- Sits between the host/UART byte source and InstructionMemory.

---
 rtl/im_loader_pkg.sv | 14 +
 rtl/im_loader_if.sv | 28 ++
 rtl/im_loader_byte_packer.sv | 29 ++
 rtl/im_loader.sv | 91 +++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: instruction width,
// stream widths and the loader state encoding.
package im_loader_pkg;
    localparam int INSTR_W = 24;
    localparam int BYTE_W  = 8;
    localparam int LEN_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ld_state_t;
endpackage

// File: rtl/im_loader_if.sv
// Loader bus: control (start/length), byte stream, memory write port and status.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 24
);
    logic               start;
    logic [LEN_W-1:0]   length;
    logic [BYTE_W-1:0]  byte_data;
    logic               byte_valid;
    logic               byte_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               cpu_hold;
    logic               done;
    logic               error;

    modport master (
        output start, length, byte_data, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        input  start, length, byte_data, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/im_loader_byte_packer.sv
// Packs three accepted bytes, MSB first, into one instruction word.
// 'full' flags the third byte so the caller can capture 'word' on that edge.
module im_loader_byte_packer
    import im_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               accept,
    input  logic [BYTE_W-1:0]  data,
    output logic [INSTR_W-1:0] word,
    output logic               full
);
    logic [1:0]          cnt;
    logic [2*BYTE_W-1:0] sh;

    assign full = accept && (cnt == 2'd2);
    // The third byte is taken straight from the input so the word is ready on its acceptance edge.
    assign word = {sh, data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            sh  <= '0;
        end else if (accept) begin
            sh  <= {sh[BYTE_W-1:0], data};
            cnt <= full ? 2'd0 : cnt + 2'd1;
        end
    end
endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: streams bytes into 24-bit words, writes them from
// BASE upward and holds the CPU in reset for the duration of the load.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input logic        clk,
    input logic        rst_n,
    im_loader_if.slave bus
);
    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

    ld_state_t          state, state_n;
    logic [LEN_W-1:0]   len_q, wcnt;
    logic               accept, full, last_word, start_bad, start_load, error_n;
    logic [INSTR_W-1:0] word;

    assign accept     = bus.byte_valid && bus.byte_ready;
    assign last_word  = (wcnt + LEN_W'(1)) == len_q;
    assign start_bad  = bus.start && ({1'b0, bus.length} > DEPTH_L);
    assign start_load = (state == IDLE) && bus.start && !start_bad && (bus.length != '0);

    im_loader_byte_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .data   (bus.byte_data),
        .word   (word),
        .full   (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        error_n = bus.error;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (start_bad) begin
                        error_n = 1'b1;
                    end else begin
                        error_n = 1'b0;
                        state_n = (bus.length == '0) ? DONE : RECV;
                    end
                end
            end
            RECV:    if (full) state_n = WRITE;
            WRITE:   state_n = last_word ? DONE : RECV;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so each one
    // lines up exactly with the cycle spent in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.byte_ready <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.done       <= 1'b0;
            bus.cpu_hold   <= 1'b0;
            bus.error      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            len_q          <= '0;
            wcnt           <= '0;
        end else begin
            bus.byte_ready <= (state_n == RECV);
            bus.wr_en      <= (state_n == WRITE);
            bus.done       <= (state_n == DONE);
            bus.cpu_hold   <= (state_n != IDLE);
            bus.error      <= error_n;
            if (start_load) begin
                len_q       <= bus.length;
                wcnt        <= '0;
                bus.wr_addr <= ADDR_W'(BASE);
            end else if (state == WRITE) begin
                wcnt        <= wcnt + LEN_W'(1);
                bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
            end
            if (full) bus.wr_data <= word;
        end
    end
endmodule
